ps_kernel_control: RTL

PS_KERNEL_CONTROL -- requirements
Module: ps_kernel_control

---
 rtl/ps_kernel_control.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/ps_kernel_control.sv
//==============================================================================
// Module  : ps_kernel_control
// Desc    : Steers a pixel stream into four line buffers and reads three of them
//           back in step to form a registered 3x3 window stream.
// Rev     : 1.0  initial release
//==============================================================================
`default_nettype none

module ps_kernel_control #(
    parameter int LINE_LENGTH = 640
) (
    input  logic        i_clk,
    input  logic        i_rstn,
    input  logic        i_valid,
    input  logic [7:0]  i_data,
    output logic [3:0]  o_lb_wr,
    output logic [7:0]  o_lb_wdata,
    output logic [3:0]  o_lb_rd,
    input  logic [23:0] i_lb_rdata0,
    input  logic [23:0] i_lb_rdata1,
    input  logic [23:0] i_lb_rdata2,
    input  logic [23:0] i_lb_rdata3,
    output logic [71:0] o_pixel,
    output logic        o_valid,
    output logic        o_overflow
);

    localparam int c_fill_w = $clog2(4 * LINE_LENGTH + 1);
    localparam int c_cnt_w  = (LINE_LENGTH > 1) ? $clog2(LINE_LENGTH) : 1;

    localparam logic [c_fill_w-1:0] c_fill_full  = c_fill_w'(4 * LINE_LENGTH);
    localparam logic [c_fill_w-1:0] c_fill_start = c_fill_w'(3 * LINE_LENGTH);
    localparam logic [c_fill_w-1:0] c_fill_one   = c_fill_w'(1);
    localparam logic [c_cnt_w-1:0]  c_cnt_last   = c_cnt_w'(LINE_LENGTH - 1);
    localparam logic [c_cnt_w-1:0]  c_cnt_one    = c_cnt_w'(1);

    localparam logic [0:0] c_s_idle = 1'b0;
    localparam logic [0:0] c_s_read = 1'b1;

    logic [0:0]          state_q,    state_d;
    logic [1:0]          wsel_q,     wsel_d;
    logic [1:0]          rsel_q,     rsel_d;
    logic [1:0]          rsel_dly_q, rsel_dly_d;
    logic [c_cnt_w-1:0]  wcount_q,   wcount_d;
    logic [c_cnt_w-1:0]  rcount_q,   rcount_d;
    logic [c_fill_w-1:0] fill_q,     fill_d;
    logic                vld1_q,     vld1_d;
    logic                vld2_q,     vld2_d;
    logic [71:0]         pixel_q,    pixel_d;
    logic                overflow_q, overflow_d;

    logic        w_full;
    logic        w_accept;
    logic        w_read;
    logic [7:0]  w_rd_rot;
    logic [1:0]  w_idx1;
    logic [1:0]  w_idx2;
    logic [23:0] w_rdata [4];

    assign w_full   = (fill_q == c_fill_full);
    assign w_accept = i_valid & ~w_full;
    assign w_read   = (state_q == c_s_read);

    assign w_rdata[0] = i_lb_rdata0;
    assign w_rdata[1] = i_lb_rdata1;
    assign w_rdata[2] = i_lb_rdata2;
    assign w_rdata[3] = i_lb_rdata3;

    assign w_idx1 = rsel_dly_q + 2'd1;
    assign w_idx2 = rsel_dly_q + 2'd2;

    assign o_lb_wdata = i_data;
    assign o_lb_wr    = (w_accept && i_rstn) ? (4'b0001 << wsel_q) : 4'b0000;
    assign o_pixel    = pixel_q;
    assign o_valid    = vld2_q;
    assign o_overflow = overflow_q;

    // FSM: state register
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            state_q <= c_s_idle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state, read counter and read-buffer select
    always_comb begin
        state_d  = state_q;
        rcount_d = rcount_q;
        rsel_d   = rsel_q;
        case (state_q)
            c_s_idle: begin
                if (fill_q >= c_fill_start) begin
                    state_d = c_s_read;
                end
            end
            c_s_read: begin
                if (rcount_q == c_cnt_last) begin
                    state_d  = c_s_idle;
                    rcount_d = '0;
                    rsel_d   = rsel_q + 2'd1;
                end else begin
                    rcount_d = rcount_q + c_cnt_one;
                end
            end
            default: state_d = c_s_idle;
        endcase
    end

    // FSM: read strobes cover the three oldest buffers, wrapping modulo 4
    always_comb begin
        w_rd_rot = {4'b0111, 4'b0111} << rsel_q;
        o_lb_rd  = 4'b0000;
        if ((state_q == c_s_read) && i_rstn) begin
            o_lb_rd = w_rd_rot[7:4];
        end
    end

    always_comb begin
        wcount_d = wcount_q;
        wsel_d   = wsel_q;
        if (w_accept) begin
            if (wcount_q == c_cnt_last) begin
                wcount_d = '0;
                wsel_d   = wsel_q + 2'd1;
            end else begin
                wcount_d = wcount_q + c_cnt_one;
            end
        end

        fill_d = fill_q;
        case ({w_accept, w_read})
            2'b10:   fill_d = fill_q + c_fill_one;
            2'b01:   fill_d = fill_q - c_fill_one;
            default: fill_d = fill_q;
        endcase

        overflow_d = overflow_q | (i_valid & w_full);

        // Buffer data arrives one cycle after its strobe, so the select lags too
        rsel_dly_d = rsel_q;
        vld1_d     = w_read;
        vld2_d     = vld1_q;
        pixel_d    = pixel_q;
        if (vld1_q) begin
            pixel_d = {w_rdata[rsel_dly_q], w_rdata[w_idx1], w_rdata[w_idx2]};
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            wsel_q     <= 2'd0;
            rsel_q     <= 2'd0;
            rsel_dly_q <= 2'd0;
            wcount_q   <= '0;
            rcount_q   <= '0;
            fill_q     <= '0;
            vld1_q     <= 1'b0;
            vld2_q     <= 1'b0;
            pixel_q    <= 72'd0;
            overflow_q <= 1'b0;
        end else begin
            wsel_q     <= wsel_d;
            rsel_q     <= rsel_d;
            rsel_dly_q <= rsel_dly_d;
            wcount_q   <= wcount_d;
            rcount_q   <= rcount_d;
            fill_q     <= fill_d;
            vld1_q     <= vld1_d;
            vld2_q     <= vld2_d;
            pixel_q    <= pixel_d;
            overflow_q <= overflow_d;
        end
    end

endmodule

`default_nettype wire
